// File: rtl/store_buffer_if.sv
// Pipeline/memory-side signal bundle for store_buffer; the buffer uses the slave modport,
// and the pipeline plus data memory environment uses the master modport.
interface store_buffer_if #(
  parameter int XLEN = 64
);
  logic            St_Valid;
  logic [XLEN-1:0] St_Addr;
  logic [XLEN-1:0] St_Data;
  logic            St_Ready;
  logic            Ld_Valid;
  logic [XLEN-1:0] Ld_Addr;
  logic [XLEN-1:0] Ld_Data;
  logic            Ld_Hit;
  logic            Stall;
  logic [XLEN-1:0] Mem_Addr;
  logic [XLEN-1:0] Write_Data;
  logic            MemWrite;
  logic            MemRead;
  logic [XLEN-1:0] Mem_Read_Data;

  modport master (
    output St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_Read_Data,
    input  St_Ready, Ld_Data, Ld_Hit, Stall, Mem_Addr, Write_Data, MemWrite, MemRead
  );

  modport slave (
    input  St_Valid, St_Addr, St_Data, Ld_Valid, Ld_Addr, Mem_Read_Data,
    output St_Ready, Ld_Data, Ld_Hit, Stall, Mem_Addr, Write_Data, MemWrite, MemRead
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular store buffer between the MEM stage and data memory.
// Optional macro STORE_FWD_EN: forward the youngest exact-match store to a load.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  addr_r [DEPTH];
  logic [XLEN-1:0]  data_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic            st_ready_s;
  logic            enq_s;
  logic            drain_s;
  logic            any_match_s;
  logic            any_overlap_s;
  logic            hit_s;
  logic            conflict_s;
  logic            mem_read_s;
  logic [XLEN-1:0] fwd_data_s;

  // Search valid entries oldest to youngest so the last exact match wins forwarding
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    logic [XLEN-1:0]  dist_v;
    logic             valid_v;
    logic             exact_v;
    logic             near_v;
    any_match_s   = 1'b0;
    any_overlap_s = 1'b0;
    fwd_data_s    = '0;
    idx_v         = '0;
    dist_v        = '0;
    valid_v       = 1'b0;
    exact_v       = 1'b0;
    near_v        = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v   = head_r + PTR_W'(k);
      valid_v = (CNT_W'(k) < count_r);
      dist_v  = (bus.Ld_Addr >= addr_r[idx_v]) ? (bus.Ld_Addr - addr_r[idx_v])
                                               : (addr_r[idx_v] - bus.Ld_Addr);
      exact_v = valid_v && (bus.Ld_Addr == addr_r[idx_v]);
      near_v  = valid_v && (dist_v < XLEN'(4'd8));
      any_match_s   = any_match_s | exact_v;
      any_overlap_s = any_overlap_s | (near_v && !exact_v);
      fwd_data_s    = exact_v ? data_r[idx_v] : fwd_data_s;
    end
  end

  // Load classification; without forwarding an exact match behaves as an overlap
  always_comb begin
`ifdef STORE_FWD_EN
    hit_s      = bus.Ld_Valid && any_match_s && !any_overlap_s;
    conflict_s = bus.Ld_Valid && any_overlap_s;
`else
    hit_s      = 1'b0;
    conflict_s = bus.Ld_Valid && (any_overlap_s || any_match_s);
`endif
    st_ready_s = (count_r < CNT_W'(DEPTH));
    enq_s      = bus.St_Valid && st_ready_s;
    drain_s    = (count_r != CNT_W'(1'b0)) && (!bus.Ld_Valid || conflict_s);
    mem_read_s = bus.Ld_Valid && !hit_s && !conflict_s;
  end

  // Drain and memory read are mutually exclusive, so one shared address mux suffices
  always_comb begin
    bus.St_Ready   = st_ready_s;
    bus.Stall      = (bus.St_Valid && !st_ready_s) || conflict_s;
    bus.Ld_Hit     = hit_s;
    bus.MemWrite   = drain_s;
    bus.MemRead    = mem_read_s;
    bus.Write_Data = drain_s ? data_r[head_r] : '0;
    bus.Mem_Addr   = drain_s ? addr_r[head_r] : (mem_read_s ? bus.Ld_Addr : '0);
    bus.Ld_Data    = hit_s ? fwd_data_s : (mem_read_s ? bus.Mem_Read_Data : '0);
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1'b1);
      end
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; validity comes from head/count, so contents need no reset
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_r[tail_r] <= bus.St_Addr;
      data_r[tail_r] <= bus.St_Data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, XLEN=64); expectations follow STORE_FWD_EN.
module tb_store_buffer;
  localparam logic [63:0] MEM_KEY = 64'hA5A5_0000_5A5A_0000;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  store_buffer_if #(.XLEN(64)) bus ();

  store_buffer #(.DEPTH(4), .XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational data memory: read data is a keyed function of the address
  assign bus.Mem_Read_Data = bus.Mem_Addr ^ MEM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                       input logic lv, input logic [63:0] la);
    bus.St_Valid = sv;
    bus.St_Addr  = sa;
    bus.St_Data  = sd;
    bus.Ld_Valid = lv;
    bus.Ld_Addr  = la;
    #1;
  endtask

  function automatic logic [63:0] wrap_addr(input int i);
    return 64'h400 + 64'(16 * i);
  endfunction

  function automatic logic [63:0] wrap_data(input int i);
    return 64'hD000_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;

    // Reset: every output zero except St_Ready
    reset = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("rst_st_ready", 64'(bus.St_Ready), 64'd1);
    check("rst_stall", 64'(bus.Stall), 64'd0);
    check("rst_memwrite", 64'(bus.MemWrite), 64'd0);
    check("rst_memread", 64'(bus.MemRead), 64'd0);
    check("rst_ld_hit", 64'(bus.Ld_Hit), 64'd0);
    check("rst_mem_addr", bus.Mem_Addr, 64'h0);
    check("rst_write_data", bus.Write_Data, 64'h0);
    check("rst_ld_data", bus.Ld_Data, 64'h0);

    // Single store drains the cycle after it is accepted
    drive(1'b1, 64'h10, 64'h1122_3344_5566_7788, 1'b0, 64'h0);
    check("t1_accept_ready", 64'(bus.St_Ready), 64'd1);
    check("t1_no_same_cycle_drain", 64'(bus.MemWrite), 64'd0);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t1_drain_mw", 64'(bus.MemWrite), 64'd1);
    check("t1_drain_addr", bus.Mem_Addr, 64'h10);
    check("t1_drain_data", bus.Write_Data, 64'h1122_3344_5566_7788);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t1_empty_mw", 64'(bus.MemWrite), 64'd0);

    // Fill with a non-overlapping load held high, then overflow and drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h200 + 64'(8 * i), 64'hF0 + 64'(i), 1'b1, 64'h100);
      check("t2_fill_memread", 64'(bus.MemRead), 64'd1);
      check("t2_fill_no_drain", 64'(bus.MemWrite), 64'd0);
      if (i == 0) begin
        check("t2_load_addr", bus.Mem_Addr, 64'h100);
        check("t2_load_data", bus.Ld_Data, 64'h100 ^ MEM_KEY);
      end
      tick();
    end
    drive(1'b1, 64'h220, 64'hFF, 1'b1, 64'h100);
    check("t2_full_ready", 64'(bus.St_Ready), 64'd0);
    check("t2_full_stall", 64'(bus.Stall), 64'd1);
    check("t2_full_no_drain", 64'(bus.MemWrite), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
      check("t2_drain_mw", 64'(bus.MemWrite), 64'd1);
      check("t2_drain_addr", bus.Mem_Addr, 64'h200 + 64'(8 * i));
      check("t2_drain_data", bus.Write_Data, 64'hF0 + 64'(i));
      check("t2_drain_ready", 64'(bus.St_Ready), (i == 0) ? 64'd0 : 64'd1);
      tick();
    end
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t2_empty_mw", 64'(bus.MemWrite), 64'd0);

    // Two stores to one address, then a load of that address
    drive(1'b1, 64'h20, 64'hAA, 1'b1, 64'h100);
    tick();
    drive(1'b1, 64'h20, 64'hBB, 1'b1, 64'h100);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h20);
`ifdef STORE_FWD_EN
    check("t3_fwd_hit", 64'(bus.Ld_Hit), 64'd1);
    check("t3_fwd_data", bus.Ld_Data, 64'hBB);
    check("t3_fwd_memread", 64'(bus.MemRead), 64'd0);
    check("t3_fwd_stall", 64'(bus.Stall), 64'd0);
    check("t3_fwd_memwrite", 64'(bus.MemWrite), 64'd0);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t3_drain0_data", bus.Write_Data, 64'hAA);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t3_drain1_data", bus.Write_Data, 64'hBB);
`else
    check("t3_nofwd_hit", 64'(bus.Ld_Hit), 64'd0);
    check("t3_nofwd_stall0", 64'(bus.Stall), 64'd1);
    check("t3_nofwd_drain0", bus.Write_Data, 64'hAA);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h20);
    check("t3_nofwd_stall1", 64'(bus.Stall), 64'd1);
    check("t3_nofwd_drain1", bus.Write_Data, 64'hBB);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h20);
    check("t3_nofwd_release", 64'(bus.Stall), 64'd0);
    check("t3_nofwd_memread", 64'(bus.MemRead), 64'd1);
    check("t3_nofwd_addr", bus.Mem_Addr, 64'h20);
    check("t3_nofwd_data", bus.Ld_Data, 64'h20 ^ MEM_KEY);
`endif
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t3_empty_mw", 64'(bus.MemWrite), 64'd0);

    // Same-cycle store+load sees pre-edge state; then a partial overlap stalls
    drive(1'b1, 64'h30, 64'h3333, 1'b1, 64'h30);
    check("t4_same_cycle_memread", 64'(bus.MemRead), 64'd1);
    check("t4_same_cycle_hit", 64'(bus.Ld_Hit), 64'd0);
    check("t4_same_cycle_stall", 64'(bus.Stall), 64'd0);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h34);
    check("t4_overlap_stall", 64'(bus.Stall), 64'd1);
    check("t4_overlap_drain", 64'(bus.MemWrite), 64'd1);
    check("t4_overlap_addr", bus.Mem_Addr, 64'h30);
    check("t4_overlap_memread", 64'(bus.MemRead), 64'd0);
    tick();
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h34);
    check("t4_release_stall", 64'(bus.Stall), 64'd0);
    check("t4_release_memread", 64'(bus.MemRead), 64'd1);
    check("t4_release_addr", bus.Mem_Addr, 64'h34);
    check("t4_release_data", bus.Ld_Data, 64'h34 ^ MEM_KEY);
    tick();

    // Pointer wrap: ten enqueue/drain pairs with interleaved loads
    drive(1'b1, wrap_addr(0), wrap_data(0), 1'b1, 64'h100);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, wrap_addr(i + 1), wrap_data(i + 1), 1'b0, 64'h0);
      check("t5_pair_mw", 64'(bus.MemWrite), 64'd1);
      check("t5_pair_addr", bus.Mem_Addr, wrap_addr(i));
      check("t5_pair_data", bus.Write_Data, wrap_data(i));
      tick();
      if ((i % 2) == 1) begin
        drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h100);
        check("t5_load_memread", 64'(bus.MemRead), 64'd1);
        check("t5_load_no_drain", 64'(bus.MemWrite), 64'd0);
        tick();
      end
    end
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t5_last_addr", bus.Mem_Addr, wrap_addr(10));
    check("t5_last_data", bus.Write_Data, wrap_data(10));
    tick();

    // Reset with three entries buffered, one draining at the reset edge
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h500 + 64'(16 * i), 64'h55 + 64'(i), 1'b1, 64'h100);
      tick();
    end
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t6_pre_reset_drain", 64'(bus.MemWrite), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b1, 64'h510);
    check("t6_post_mw", 64'(bus.MemWrite), 64'd0);
    check("t6_post_ready", 64'(bus.St_Ready), 64'd1);
    check("t6_post_hit", 64'(bus.Ld_Hit), 64'd0);
    check("t6_post_memread", 64'(bus.MemRead), 64'd1);
    check("t6_post_stall", 64'(bus.Stall), 64'd0);
    check("t6_post_addr", bus.Mem_Addr, 64'h510);
    drive(1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
    check("t6_idle_mw", 64'(bus.MemWrite), 64'd0);
    check("t6_idle_addr", bus.Mem_Addr, 64'h0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, minimum 2.
REQ-002 Parameter XLEN, default 64, address and data width in bits.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 St_Valid  in  1  MEM-stage store request.
REQ-006 St_Addr  in  XLEN  store byte address.
REQ-007 St_Data  in  XLEN  store doubleword.
REQ-008 St_Ready  out  1  buffer can accept a store this cycle.
REQ-009 Ld_Valid  in  1  MEM-stage load request.
REQ-010 Ld_Addr  in  XLEN  load byte address.
REQ-011 Ld_Data  out  XLEN  load result: forwarded or from memory.
REQ-012 Ld_Hit  out  1  load satisfied from the buffer.
REQ-013 Stall  out  1  pipeline hold request.
REQ-014 Mem_Addr  out  XLEN  address to data memory.
REQ-015 Write_Data  out  XLEN  write data to data memory.
REQ-016 MemWrite  out  1  data memory write enable.
REQ-017 MemRead  out  1  data memory read enable.
REQ-018 Mem_Read_Data  in  XLEN  data memory combinational read result.

Function
REQ-019 Circular FIFO of DEPTH entries {addr, data}: head and tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-020 St_Ready = (count < DEPTH), computed from registered count only; a same-cycle drain does not free space.
REQ-021 St_Valid && St_Ready: entry written at tail on posedge; tail and count increment.
REQ-022 Entry address match: Ld_Addr == entry addr. Entry overlap: unsigned |Ld_Addr - entry addr| < 8 with no match.
REQ-023 Ld_Hit = Ld_Valid && some valid entry matches && no valid entry overlaps; Ld_Data = data of the youngest matching entry (closest to tail), combinational.
REQ-024 Ld_Conflict = Ld_Valid && some valid entry overlaps.
REQ-025 Stall = (St_Valid && !St_Ready) || Ld_Conflict.
REQ-026 Drain condition: count > 0 && (!Ld_Valid || Ld_Conflict); when true, MemWrite = 1, Mem_Addr = head addr, and Write_Data = head data. Head advances and count decrements on posedge.
REQ-027 MemRead = Ld_Valid && !Ld_Hit && !Ld_Conflict; then Mem_Addr = Ld_Addr and Ld_Data = Mem_Read_Data.
REQ-028 MemWrite and MemRead are never both 1; when neither is 1, Mem_Addr, Write_Data and Ld_Data are 0.
REQ-029 Enqueue and drain in the same cycle: count unchanged; both pointers advance.
REQ-030 Minimum store-to-memory latency is 1 cycle: a store accepted at edge N drains no earlier than the cycle after edge N.
REQ-031 St_Valid and Ld_Valid together: the store is enqueued, and the load sees only pre-edge buffer contents.
REQ-032 Ld_Conflict holds Stall until every overlapping entry has drained. Draining proceeds despite Ld_Valid, so no deadlock occurs.

Reset
REQ-033 On reset, count, head and tail are 0 and all entries are invalid; contents are not cleared.
REQ-034 One cycle after a reset edge, every output is 0 except St_Ready = 1. Stores pending at reset are discarded, including one draining that cycle.

Configuration
REQ-035 With STORE_FWD_EN defined, REQ-023 forwarding applies.
REQ-036 Without STORE_FWD_EN, Ld_Hit is tied 0 and exact matches count as overlaps, so any load touching a buffered address stalls until that entry drains.

Verification
REQ-037 Reset, then store A=0x10 D=0x1122334455667788; next cycle with no load: MemWrite=1, Mem_Addr=0x10, Write_Data=D; count returns to 0.
REQ-038 Fill DEPTH=4 stores with Ld_Valid held high at non-overlapping 0x100: St_Ready=0; 5th St_Valid gives Stall=1; drop Ld_Valid: one drain per cycle, St_Ready=1 after the first drain.
REQ-039 Stores 0x20=0xAA then 0x20=0xBB buffered; load 0x20 with STORE_FWD_EN: Ld_Hit=1, Ld_Data=0xBB, MemRead=0; without it: Stall=1 until both drain, then MemRead=1.
REQ-040 Buffered store 0x30; load 0x34: Stall=1 and drain occurs the same cycle; the next cycle Stall=0 and MemRead=1 with Mem_Addr=0x34.
REQ-041 Head/tail wrap: 10 enqueue/drain pairs with DEPTH=4 and interleaved loads; every write reaches memory in program order with correct data.
REQ-042 Reset asserted with 3 entries buffered: the next cycle MemWrite=0, St_Ready=1, and a load to a buffered address gives Ld_Hit=0 and MemRead=1.
